// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage bus: decoded instruction fields from ID, registered copies to EX,
// plus the stall request back to PC and IF/ID.
interface id_ex_pipe_reg_if;
    logic        valid_i,    valid_o;
    logic        RegWrite_i, RegWrite_o;
    logic        MemtoReg_i, MemtoReg_o;
    logic        MemRead_i,  MemRead_o;
    logic        MemWrite_i, MemWrite_o;
    logic        ALUSrc_i,   ALUSrc_o;
    logic        RegDst_i,   RegDst_o;
    logic [1:0]  ALUOp_i,    ALUOp_o;
    logic [31:0] rs_data_i,  rs_data_o;
    logic [31:0] rt_data_i,  rt_data_o;
    logic [31:0] imm_i,      imm_o;
    logic [4:0]  rs_addr_i,  rs_addr_o;
    logic [4:0]  rt_addr_i,  rt_addr_o;
    logic [4:0]  rd_addr_i,  rd_addr_o;
    logic        hold_i;
    logic        flush_i;
    logic [5:0]  funct_o;
    logic        stall_o;
    logic [31:0] bubble_cnt_o;

    modport master (
        output valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i,
               ALUOp_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
               hold_i, flush_i,
        input  valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o,
               ALUOp_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o,
               funct_o, stall_o, bubble_cnt_o
    );

    modport slave (
        input  valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i,
               ALUOp_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
               hold_i, flush_i,
        output valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o,
               ALUOp_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o,
               funct_o, stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush, hold and load-use bubble insertion.
// Define ID_EX_HAZARD_EN to build load-use detection and the saturating bubble counter.
module id_ex_pipe_reg (
    input  logic             clk_i,
    input  logic             rst_i,
    id_ex_pipe_reg_if.slave  bus
);

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [1:0]  alu_op;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
    } stage_t;

    stage_t stage_reg;
    stage_t stage_next;
    logic   hazard;

    always_comb begin
        stage_next            = '0;
        stage_next.valid      = bus.valid_i;
        stage_next.reg_write  = bus.RegWrite_i;
        stage_next.mem_to_reg = bus.MemtoReg_i;
        stage_next.mem_read   = bus.MemRead_i;
        stage_next.mem_write  = bus.MemWrite_i;
        stage_next.alu_src    = bus.ALUSrc_i;
        stage_next.reg_dst    = bus.RegDst_i;
        stage_next.alu_op     = bus.ALUOp_i;
        stage_next.rs_data    = bus.rs_data_i;
        stage_next.rt_data    = bus.rt_data_i;
        stage_next.imm        = bus.imm_i;
        stage_next.rs_addr    = bus.rs_addr_i;
        stage_next.rt_addr    = bus.rt_addr_i;
        stage_next.rd_addr    = bus.rd_addr_i;
    end

`ifdef ID_EX_HAZARD_EN
    // Compares against both source fields even when rt is not read: conservative on purpose.
    assign hazard = stage_reg.valid & stage_reg.mem_read & (stage_reg.rt_addr != 5'd0) &
                    bus.valid_i &
                    ((stage_reg.rt_addr == bus.rs_addr_i) | (stage_reg.rt_addr == bus.rt_addr_i));
`else
    assign hazard = 1'b0;
`endif

    assign bus.stall_o = bus.hold_i | (hazard & ~bus.flush_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_reg <= '0;
        end else if (bus.flush_i) begin
            stage_reg <= '0;
        end else if (bus.hold_i) begin
            stage_reg <= stage_reg;
        end else if (hazard) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

`ifdef ID_EX_HAZARD_EN
    logic [31:0] bubble_cnt_reg;

    // Only load-use bubbles are counted; flush and hold take priority over the hazard.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_reg <= '0;
        end else if (!bus.flush_i && !bus.hold_i && hazard && (bubble_cnt_reg != 32'hFFFF_FFFF)) begin
            bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
        end
    end

    assign bus.bubble_cnt_o = bubble_cnt_reg;
`else
    assign bus.bubble_cnt_o = 32'd0;
`endif

    assign bus.valid_o    = stage_reg.valid;
    assign bus.RegWrite_o = stage_reg.reg_write;
    assign bus.MemtoReg_o = stage_reg.mem_to_reg;
    assign bus.MemRead_o  = stage_reg.mem_read;
    assign bus.MemWrite_o = stage_reg.mem_write;
    assign bus.ALUSrc_o   = stage_reg.alu_src;
    assign bus.RegDst_o   = stage_reg.reg_dst;
    assign bus.ALUOp_o    = stage_reg.alu_op;
    assign bus.rs_data_o  = stage_reg.rs_data;
    assign bus.rt_data_o  = stage_reg.rt_data;
    assign bus.imm_o      = stage_reg.imm;
    assign bus.rs_addr_o  = stage_reg.rs_addr;
    assign bus.rt_addr_o  = stage_reg.rt_addr;
    assign bus.rd_addr_o  = stage_reg.rd_addr;
    assign bus.funct_o    = stage_reg.imm[5:0];

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register for the 5-stage MIPS core, directly upstream of the ALU control and ALU. It captures decoded control bits, operands and register addresses each cycle and presents `ALUOp_o`/`funct_o` to the ALU control stage in EX. It applies flush, hold and load-use bubble insertion, and keeps a saturating count of inserted bubbles.

## Interface
- No parameters; all widths are fixed.
- Clock `clk_i`; reset `rst_i` (asynchronous, active-high).
- `clk_i` in 1: rising-edge clock.
- `rst_i` in 1: asynchronous active-high reset.
- `valid_i` in 1: ID holds a real instruction.
- `RegWrite_i`, `MemtoReg_i`, `MemRead_i`, `MemWrite_i`, `ALUSrc_i`, `RegDst_i` in 1 each: decoded control bits.
- `ALUOp_i` in 2: ALU operation class.
- `rs_data_i`, `rt_data_i`, `imm_i` in 32 each: operands and sign-extended immediate.
- `rs_addr_i`, `rt_addr_i`, `rd_addr_i` in 5 each: register numbers.
- `hold_i` in 1: downstream stall; freeze this register.
- `flush_i` in 1: branch/jump squash; load a bubble.
- `*_o` out (same width as the matching `*_i`): registered copies of every input above except `hold_i`/`flush_i`.
- `funct_o` out 6: equals `imm_o[5:0]`.
- `stall_o` out 1: comb; freeze PC and IF/ID this cycle.
- `bubble_cnt_o` out 32: load-use bubbles inserted since reset.

## Operation
- Bubble = `valid_o`, all six control bits and `ALUOp_o` set to 0. `rs/rt/rd_addr_o` set to 0. `rs_data_o`, `rt_data_o` and `imm_o` set to 0.
- Hazard (comb) = `valid_o & MemRead_o & (rt_addr_o != 0) & valid_i & (rt_addr_o == rs_addr_i | rt_addr_o == rt_addr_i)`.
- The hazard term always compares both `rs` and `rt`, whether or not the instruction reads `rt`. This is conservative by design.
- `stall_o = hold_i | (hazard & ~flush_i)`.
- Per-edge priority, highest first:
  1. `flush_i`: load a bubble. A flush overrides both hold and hazard.
  2. `hold_i`: keep all registers unchanged.
  3. hazard: load a bubble and increment `bubble_cnt_o`.
  4. Otherwise: capture all `*_i` inputs.
- When `valid_i=0`, the inputs are still captured as-is, with `valid_o=0`. The control bits pass through unmodified; the decoder is responsible for zeroing them.
- `bubble_cnt_o` increments only on priority case 3 and saturates at 0xFFFFFFFF. Flush bubbles and hold cycles are not counted.

## Timing
- Latency: one cycle from ID inputs to `*_o`.
- Reset: every `*_o` = 0 (bubble state); `bubble_cnt_o` = 0; `stall_o` = `hold_i`.
- A reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- A load-use pair costs exactly one bubble. On the next edge the load has moved on (`MemRead_o=0`), so the hazard term drops and the held dependent instruction is captured.
- If `hold_i` and the hazard are both active, nothing changes and the counter does not increment. The hazard is re-evaluated after the hold is released.
- `stall_o` is combinational from `hold_i`, `flush_i`, `valid_i`, `rs_addr_i`, `rt_addr_i` and register state. There is no path from `stall_o` back into those inputs within this block.

## Configuration
- Macro `ID_EX_HAZARD_EN`.
- Defined: load-use detection, bubble insertion and `bubble_cnt_o` operate as described above.
- Undefined:
  - The hazard term is constant 0 and `stall_o = hold_i`.
  - `bubble_cnt_o` is constant 0 and no counter flops are built.
  - In this build, software or the forwarding unit owns load-use correctness.

## Test plan
- Reset, then release; apply `valid_i=1`, `ALUOp_i=2'b10`, `imm_i=32'h0000002A` -> one edge later `valid_o=1`, `ALUOp_o=2'b10`, `funct_o=6'b101010`. Assert `rst_i` between edges -> every output is 0 at once.
- Load of `$t0` in EX (`MemRead_o=1`, `rt_addr_o=8`); ID presents `rs_addr_i=8` -> `stall_o=1`, next edge is a bubble, `bubble_cnt_o=1`. The following edge captures the dependent instruction with `stall_o=0`.
- Same as above but with `rt_addr_o=0` -> no stall and no bubble; `bubble_cnt_o` stays 0.
- Hazard present and `flush_i=1` in the same cycle -> `stall_o=hold_i`, a bubble is loaded, and the counter is unchanged.
- `hold_i=1` for 3 cycles while the inputs toggle -> outputs stay frozen and `stall_o=1`. On release, the current inputs are captured.
- Force the counter to 0xFFFFFFFE, then cause 2 hazard bubbles -> `bubble_cnt_o=0xFFFFFFFF` after both. Repeat the hazard with the macro undefined -> `stall_o=0` and the count stays 0.
